frame_rect_filler: RTL and testbench
====================================

# frame_rect_filler

Upstream pixel source for the VGA frame driver's write port. On a start request it fills an axis-aligned rectangle of the 160x120 virtual frame with one 24-bit colour. It emits exactly one single-cycle write strobe per virtual pixel, on the same address/data/strobe port the frame driver already accepts. Game logic uses it to draw bars, customers and the player without per-pixel bookkeeping.

## Interface
- VIRT_W, 160, virtual frame width in pixels
- VIRT_H, 120, virtual frame height in pixels
- ADDR_W, 15, frame-memory address width
- DATA_W, 24, pixel colour width ({R,G,B}, 8 bits each)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- sync_frame  in  1  when 1 at start, filling waits for the next frame_done
- frame_done  in  1  end-of-frame pulse from the frame driver
- x0  in  8  left column
- y0  in  7  top row
- w  in  8  width in pixels (0..255)
- h  in  7  height in pixels (0..127)
- color  in  DATA_W  fill colour
- busy  out  1  request accepted and not yet finished
- done  out  1  one-cycle completion pulse
- wr_addr  out  ADDR_W  frame write address
- wr_data  out  DATA_W  frame write data
- wr_en  out  1  one-cycle write strobe

## Operation
- States: IDLE, WAIT_FRAME, SETUP, FILL, DONE.
- IDLE:
  - If start=1, latch x0, y0, w, h, color and sync_frame.
  - Go to WAIT_FRAME if sync_frame=1, else go to SETUP.
  - start in any other state is ignored; it is not queued.
- WAIT_FRAME: go to SETUP on the first cycle with frame_done=1.
  - A frame_done in the same cycle as the start is not counted.
- SETUP: clip and compute the base address.
  - If x0>=VIRT_W, y0>=VIRT_H, w=0 or h=0: go to DONE with zero writes.
  - Otherwise w_eff = min(w, VIRT_W-x0) and h_eff = min(h, VIRT_H-y0).
  - row_base = y0*VIRT_W + x0, computed as (y0<<7)+(y0<<5)+x0; no multiplier.
- FILL: one write per cycle, in raster order (column fastest).
  - wr_addr = row_base + col.
  - At the end of each row: col resets to 0, row_base += VIRT_W, row increments.
  - After write number w_eff*h_eff, go to DONE.
- DONE: pulse done for one cycle, then return to IDLE.
- wr_data holds the latched colour for the whole fill; a change on the color input mid-fill has no effect.
- Widths:
  - Address arithmetic is ADDR_W bits; the maximum address is 19199.
  - col is 8 bits and row is 7 bits.
  - min() comparisons are done at 9 bits so there is no wrap.

## Timing
- Reset values: busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0; state IDLE.
- An asserted rst mid-fill abandons the fill immediately: no further writes and no done pulse.
- All outputs are registered.
- Cycle numbering, without sync: start sampled at cycle 0; SETUP at cycle 1.
  - wr_en is high in cycles 2 .. 1+N, where N = w_eff*h_eff.
  - The writes are contiguous with no gaps.
  - done is high in cycle 2+N, and wr_en is low in that cycle.
- busy is high from cycle 1 through the done cycle inclusive. The next start is accepted in the cycle after done.
- Zero-area request: done in cycle 2, wr_en never asserted.
- With sync: the whole sequence is shifted to begin the cycle after frame_done is seen.
- wr_addr and wr_data are valid whenever wr_en=1. They hold their last value otherwise.

## Structure
- Shared package frame_pkg holds:
  - VIRT_W, VIRT_H, ADDR_W, DATA_W and MEMORY_SIZE=19200;
  - the state encoding (8-bit localparams, same width as other FSMs in the design).
- One combinational sub-module, rect_clip, computes w_eff, h_eff and an empty flag from x0, y0, w, h. It is reused later by the sprite blitter.
- The FSM and the address counters live in frame_rect_filler.

## Test plan
- x0=10, y0=5, w=3, h=2, colour 24'hFF0000 -> wr_en high in cycles 2–7 with addresses 810, 811, 812, 970, 971, 972, all data FF0000; done in cycle 8; busy high in cycles 1–8.
- x0=158, y0=119, w=5, h=4 -> exactly 2 writes (19198, 19199); done in cycle 4.
- w=0 (any other fields), then x0=200, w=10 -> no wr_en in either case; done in cycle 2 each time.
- x0=0, y0=0, w=255, h=127 -> 19200 contiguous writes, addresses 0..19199; done in cycle 19202.
- sync_frame=1, frame_done pulsed 50 cycles after start, x0=0, y0=0, w=1, h=1 -> no wr_en before frame_done; a single write to address 0 two cycles after frame_done.
- Start a 160x120 fill, drop rst at cycle 100, hold it 3 cycles, release -> all outputs 0 during reset; no writes or done after release; a new start is accepted normally.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared constants and FSM state encoding for the frame pixel sources.
package frame_pkg;

  localparam int unsigned VIRT_W      = 160;
  localparam int unsigned VIRT_H      = 120;
  localparam int unsigned ADDR_W      = 15;
  localparam int unsigned DATA_W      = 24;
  localparam int unsigned MEMORY_SIZE = 19200;

  // 8-bit encoding keeps state registers uniform with the other FSMs
  typedef enum logic [7:0] {
    ST_IDLE       = 8'd0,
    ST_WAIT_FRAME = 8'd1,
    ST_SETUP      = 8'd2,
    ST_FILL       = 8'd3,
    ST_DONE       = 8'd4
  } fill_state_e;

  // y*VIRT_W + x using shifts only: y*160 = (y<<7) + (y<<5)
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [6:0] y,
                                                   input logic [7:0] x);
    logic [ADDR_W-1:0] yw;
    yw = {8'b0, y};
    return (yw << 7) + (yw << 5) + {7'b0, x};
  endfunction

endpackage

// File: rtl/frame_rect_filler_if.sv
// Request and frame-write port bundle for the rectangle filler.
interface frame_rect_filler_if;
  import frame_pkg::*;

  logic              start;
  logic              sync_frame;
  logic              frame_done;
  logic [7:0]        x0;
  logic [6:0]        y0;
  logic [7:0]        w;
  logic [6:0]        h;
  logic [DATA_W-1:0] color;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  modport master (
    output start, sync_frame, frame_done, x0, y0, w, h, color,
    input  busy, done, wr_addr, wr_data, wr_en
  );

  modport slave (
    input  start, sync_frame, frame_done, x0, y0, w, h, color,
    output busy, done, wr_addr, wr_data, wr_en
  );

endinterface

// File: rtl/frame_rect_filler_rect_clip.sv
// Clips a rectangle against the virtual frame; pure combinational.
module rect_clip
  import frame_pkg::*;
(
  input  logic [7:0] x0_i,
  input  logic [6:0] y0_i,
  input  logic [7:0] w_i,
  input  logic [6:0] h_i,
  output logic [7:0] w_eff_o,
  output logic [6:0] h_eff_o,
  output logic       empty_o
);

  logic [8:0] x_room;
  logic [8:0] y_room;
  logic       x_off;
  logic       y_off;

  // 9-bit room to the frame edge; it is zero or negative (bit 8) exactly
  // when the origin lies outside the frame
  always_comb begin
    x_room  = 9'(VIRT_W) - {1'b0, x0_i};
    y_room  = 9'(VIRT_H) - {2'b0, y0_i};
    x_off   = x_room[8] || (x_room == '0);
    y_off   = y_room[8] || (y_room == '0);
    empty_o = x_off || y_off || (w_i == '0) || (h_i == '0);
    w_eff_o = ({1'b0, w_i} < x_room) ? w_i : x_room[7:0];
    h_eff_o = ({2'b0, h_i} < y_room) ? h_i : y_room[6:0];
  end

endmodule

// File: rtl/frame_rect_filler.sv
// Fills a clipped rectangle of the virtual frame with one colour,
// one write strobe per pixel in raster order.
module frame_rect_filler
  import frame_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  frame_rect_filler_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(VIRT_W);

  fill_state_e       state_q;
  logic [7:0]        x0_q;
  logic [6:0]        y0_q;
  logic [7:0]        w_q;
  logic [6:0]        h_q;
  logic [DATA_W-1:0] color_q;
  logic [7:0]        col_q;
  logic [6:0]        row_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [7:0]        w_eff;
  logic [6:0]        h_eff;
  logic              empty;
  logic              last_col;
  logic              last_row;
  logic [ADDR_W-1:0] base_d;

  rect_clip u_clip (
    .x0_i    (x0_q),
    .y0_i    (y0_q),
    .w_i     (w_q),
    .h_i     (h_q),
    .w_eff_o (w_eff),
    .h_eff_o (h_eff),
    .empty_o (empty)
  );

  // Position of the write currently on the port relative to the clipped size
  always_comb begin
    last_col = (col_q == w_eff - 8'd1);
    last_row = (row_q == h_eff - 7'd1);
    base_d   = pixel_addr(y0_q, x0_q);
  end

  // Request FSM with address counters; outputs are the registers themselves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            x0_q    <= bus.x0;
            y0_q    <= bus.y0;
            w_q     <= bus.w;
            h_q     <= bus.h;
            color_q <= bus.color;
            busy_q  <= 1'b1;
            state_q <= bus.sync_frame ? ST_WAIT_FRAME : ST_SETUP;
          end
        end
        ST_WAIT_FRAME: begin
          if (bus.frame_done) state_q <= ST_SETUP;
        end
        ST_SETUP: begin
          if (empty) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            // first write goes straight onto the port here, so FILL only
            // has to decide what follows the pixel currently presented
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= base_d;
            wr_addr_q  <= base_d;
            wr_data_q  <= color_q;
            wr_en_q    <= 1'b1;
            state_q    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (last_col) begin
            if (last_row) begin
              wr_en_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              col_q      <= '0;
              row_q      <= row_q + 7'd1;
              row_base_q <= row_base_q + ROW_STEP;
              wr_addr_q  <= row_base_q + ROW_STEP;
            end
          end else begin
            col_q     <= col_q + 8'd1;
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_frame_rect_filler.sv
// Self-checking bench for frame_rect_filler against a pixel-loop model.
module tb_frame_rect_filler;
  import frame_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  frame_rect_filler_if bus();

  frame_rect_filler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Reference: walk every pixel of the requested rectangle, keep on-frame ones
  task automatic build_model(input int x0, input int y0, input int w, input int h);
    exp_q.delete();
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++)
        if (xx < int'(VIRT_W) && yy < int'(VIRT_H))
          exp_q.push_back(yy * int'(VIRT_W) + xx);
  endtask

  // Issues one request at the current cycle (cycle 0) and checks every
  // cycle up to done+tail. Leaves the bench tail cycles after done.
  task automatic run_req(input string name, input int x0, input int y0,
                         input int w, input int h, input logic [23:0] col,
                         input bit sync, input int fd_delay, input bit fd_at_start,
                         input int tail);
    int n, off, first, last, done_exp;
    logic busy_exp, done_x, wen_exp;
    build_model(x0, y0, w, h);
    n        = exp_q.size();
    off      = sync ? fd_delay : 0;
    first    = off + 2;
    last     = off + 1 + n;
    done_exp = off + 2 + n;
    bus.x0 = 8'(x0); bus.y0 = 7'(y0); bus.w = 8'(w); bus.h = 7'(h);
    bus.color = col; bus.sync_frame = sync; bus.start = 1'b1;
    bus.frame_done = sync ? fd_at_start : 1'($urandom_range(0, 1));
    for (int cyc = 1; cyc <= done_exp + tail; cyc++) begin
      @(posedge clk); #1;
      busy_exp = (cyc <= done_exp);
      done_x   = (cyc == done_exp);
      wen_exp  = (cyc >= first) && (cyc <= last);
      checks++;
      if (bus.busy !== busy_exp) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, cyc, bus.busy, busy_exp);
      end
      checks++;
      if (bus.done !== done_x) begin
        errors++;
        $display("FAIL %s done cyc=%0d got=%b exp=%b", name, cyc, bus.done, done_x);
      end
      checks++;
      if (bus.wr_en !== wen_exp) begin
        errors++;
        $display("FAIL %s wr_en cyc=%0d got=%b exp=%b", name, cyc, bus.wr_en, wen_exp);
      end
      if (wen_exp) begin
        checks++;
        if (bus.wr_addr !== ADDR_W'(exp_q[cyc - first])) begin
          errors++;
          $display("FAIL %s wr_addr cyc=%0d got=%0d exp=%0d", name, cyc, bus.wr_addr, exp_q[cyc - first]);
        end
        checks++;
        if (bus.wr_data !== col) begin
          errors++;
          $display("FAIL %s wr_data cyc=%0d got=%h exp=%h", name, cyc, bus.wr_data, col);
        end
      end
      if (done_x && n > 0) begin
        checks++;
        if (bus.wr_addr !== ADDR_W'(exp_q[n - 1])) begin
          errors++;
          $display("FAIL %s addr_hold cyc=%0d got=%0d exp=%0d", name, cyc, bus.wr_addr, exp_q[n - 1]);
        end
      end
      // scramble request fields: they must already be latched / ignored
      bus.start = (cyc <= done_exp) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.color = 24'($urandom);
      bus.x0 = 8'($urandom); bus.y0 = 7'($urandom);
      bus.w = 8'($urandom);  bus.h = 7'($urandom);
      bus.sync_frame = 1'($urandom_range(0, 1));
      if (sync && cyc < fd_delay) bus.frame_done = 1'b0;
      else if (sync && cyc == fd_delay) bus.frame_done = 1'b1;
      else bus.frame_done = 1'($urandom_range(0, 1));
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.sync_frame = 1'b0; bus.frame_done = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0; bus.color = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.wr_en, bus.wr_addr, bus.wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b wr_en=%b addr=%0d data=%h exp all zero",
               bus.busy, bus.done, bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_req("basic", 10, 5, 3, 2, 24'hFF0000, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_clip_corner();
    run_req("corner", 158, 119, 5, 4, 24'h00FF00, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_zero_area();
    run_req("zero_w", int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), 0,
            int'($urandom_range(1, 127)), 24'h123456, 1'b0, 0, 1'b0, 3);
    run_req("off_x", 200, int'($urandom_range(0, 119)), 10,
            int'($urandom_range(1, 127)), 24'h654321, 1'b0, 0, 1'b0, 3);
    run_req("off_y", 5, 120, 10, 3, 24'hABCDEF, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_full_frame();
    run_req("full", 0, 0, 255, 127, 24'h0000FF, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_sync();
    run_req("sync", 0, 0, 1, 1, 24'hC0FFEE, 1'b1, 50, 1'b1, 3);
  endtask

  task automatic test_back_to_back();
    run_req("b2b_a", 20, 30, 4, 3, 24'h111111, 1'b0, 0, 1'b0, 1);
    run_req("b2b_b", 159, 0, 7, 2, 24'h222222, 1'b0, 0, 1'b0, 1);
    run_req("b2b_c", 0, 100, 0, 2, 24'h333333, 1'b0, 0, 1'b0, 1);
    run_req("b2b_d", 1, 1, 2, 2, 24'h444444, 1'b1, 5, 1'b0, 3);
  endtask

  task automatic test_reset_mid_fill();
    bus.x0 = '0; bus.y0 = '0; bus.w = 8'd160; bus.h = 7'd120;
    bus.color = 24'hDEAD00; bus.sync_frame = 1'b0; bus.frame_done = 1'b0;
    bus.start = 1'b1;
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    checks++;
    if (bus.wr_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre wr_en got=%b exp=1", bus.wr_en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.wr_en, bus.wr_addr, bus.wr_data} !== '0) begin
        errors++;
        $display("FAIL rst_hold k=%0d got busy=%b done=%b wr_en=%b addr=%0d data=%h exp all zero",
                 k, bus.busy, bus.done, bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.busy, bus.done, bus.wr_en} !== 3'b000) begin
        errors++;
        $display("FAIL rst_after cyc=%0d got busy=%b done=%b wr_en=%b exp 000",
                 cyc, bus.busy, bus.done, bus.wr_en);
      end
    end
    run_req("post_rst", 3, 4, 5, 2, 24'h0F0F0F, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      bit s;
      s = 1'($urandom_range(0, 1));
      run_req("rand", int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 40)), int'($urandom_range(0, 20)), 24'($urandom),
              s, int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip_corner();
    test_zero_area();
    test_full_frame();
    test_sync();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
